// File: rtl/l2todr_req_credit_pkg.sv
// Shared request/snack types and pipe-select constants for the L2-to-directory
// credit tracker.
package l2todr_req_credit_pkg;

  // Source pipe lives in nid[4:3].
  localparam int NID_PIPE_MSB = 4;
  localparam int NID_PIPE_LSB = 3;

`ifdef SC_4PIPE
  localparam int NPIPES_DEF = 4;
`else
  localparam int NPIPES_DEF = 2;
`endif

  typedef struct packed {
    logic [4:0]  nid;
    logic [5:0]  l2id;
    logic [2:0]  cmd;
    logic [38:0] paddr;
  } I_l2todr_req_type;

  typedef struct packed {
    logic [4:0]  nid;
    logic [5:0]  l2id;
    logic [2:0]  snack;
    logic [31:0] line;
  } I_drtol2_snack_type;

  // Pipe index carried by a node id.
  function automatic logic [1:0] nid_pipe(input logic [4:0] nid);
    return nid[NID_PIPE_MSB:NID_PIPE_LSB];
  endfunction

endpackage

// File: rtl/fflop.sv
// One-entry registered valid/retry stage. Full throughput: while the stage is
// full and the consumer accepts, a new word loads in the same cycle.
// Handshake: a transfer happens on a channel when valid=1 and retry=0 in the
// same cycle; the producer holds payload steady while valid && retry.
module fflop #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  output logic             din_retry,
  input  logic [WIDTH-1:0] din,
  output logic             q_valid,
  input  logic             q_retry,
  output logic [WIDTH-1:0] q
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_load_ok;

  assign w_load_ok = ~r_valid | ~q_retry;
  assign din_retry = r_valid & q_retry;
  assign q_valid   = r_valid;
  assign q         = r_data;

  // Hold the word while the consumer retries, otherwise take the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load_ok) begin
      r_valid <= din_valid;
      if (din_valid) r_data <= din;
    end
  end

endmodule

// File: rtl/l2todr_req_credit_cnt.sv
// Outstanding-request counter for one source pipe.
module l2todr_credit_cnt #(
  parameter int MAX_OUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] cnt,
  output logic       at_max,
  output logic       underflow
);

  logic [2:0] r_cnt;

  assign cnt       = r_cnt;
  assign at_max    = (r_cnt == 3'(MAX_OUT));
  assign underflow = dec & (r_cnt == 3'd0);

  // Simultaneous inc/dec cancel; saturate at both ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 3'd0;
    end else if (inc && !dec && !at_max) begin
      r_cnt <= r_cnt + 3'd1;
    end else if (dec && !inc && r_cnt != 3'd0) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

endmodule

// File: rtl/l2todr_req_credit.sv
// Per-pipe credit tracker between the L2 request arbiter and the directory.
// Requests are retried once their pipe has MAX_OUT outstanding; a credit
// returns when a response snack (l2id != 0) is handed to the arbiter.
module l2todr_req_credit
  import l2todr_req_credit_pkg::*;
#(
  parameter int MAX_OUT = 4,
  parameter int NPIPES  = NPIPES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_req_valid,
  output logic               in_req_retry,
  input  I_l2todr_req_type   in_req,
  output logic               l2todr_req_valid,
  input  logic               l2todr_req_retry,
  output I_l2todr_req_type   l2todr_req,
  input  logic               drtol2_snack_valid,
  output logic               drtol2_snack_retry,
  input  I_drtol2_snack_type drtol2_snack,
  output logic               out_snack_valid,
  input  logic               out_snack_retry,
  output I_drtol2_snack_type out_snack,
  output logic               credit_err
);

  localparam int RW = $bits(I_l2todr_req_type);
  localparam int SW = $bits(I_drtol2_snack_type);

  logic [1:0]      w_req_pipe;
  logic            w_req_tracked;
  logic            w_req_at_max;
  logic            w_req_ff_retry;
  logic            w_req_xfer;
  logic [1:0]      w_snk_pipe;
  logic            w_rsp_xfer;
  logic [RW-1:0]   w_req_q;
  logic [SW-1:0]   w_snk_q;
  logic [3:0]      w_inc;
  logic [3:0]      w_dec;
  logic [3:0]      w_at_max;
  logic [3:0]      w_underflow;
  logic [3:0][2:0] w_cnt;
  logic            r_credit_err;

  assign w_req_pipe    = nid_pipe(in_req.nid);
  assign w_req_tracked = (int'(w_req_pipe) < NPIPES);
  assign w_req_at_max  = w_req_tracked & w_at_max[w_req_pipe];
  assign in_req_retry  = w_req_ff_retry | (in_req_valid & w_req_at_max);
  assign w_req_xfer    = in_req_valid & ~in_req_retry;

  fflop #(.WIDTH(RW)) u_req_ff (
    .clk       (clk),
    .reset     (reset),
    .din_valid (in_req_valid & ~w_req_at_max),
    .din_retry (w_req_ff_retry),
    .din       (in_req),
    .q_valid   (l2todr_req_valid),
    .q_retry   (l2todr_req_retry),
    .q         (w_req_q)
  );
  assign l2todr_req = I_l2todr_req_type'(w_req_q);

  fflop #(.WIDTH(SW)) u_snk_ff (
    .clk       (clk),
    .reset     (reset),
    .din_valid (drtol2_snack_valid),
    .din_retry (drtol2_snack_retry),
    .din       (drtol2_snack),
    .q_valid   (out_snack_valid),
    .q_retry   (out_snack_retry),
    .q         (w_snk_q)
  );
  assign out_snack = I_drtol2_snack_type'(w_snk_q);

  // Credit returns when the arbiter actually takes the response.
  assign w_snk_pipe = nid_pipe(out_snack.nid);
  assign w_rsp_xfer = out_snack_valid & ~out_snack_retry & (out_snack.l2id != 6'd0);

  for (genvar p = 0; p < 4; p++) begin : g_pipe
    assign w_inc[p] = w_req_xfer & w_req_tracked & (w_req_pipe == 2'(p));
    assign w_dec[p] = w_rsp_xfer & (w_snk_pipe == 2'(p));
    if (p < NPIPES) begin : g_trk
      l2todr_credit_cnt #(.MAX_OUT(MAX_OUT)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (w_inc[p]),
        .dec       (w_dec[p]),
        .cnt       (w_cnt[p]),
        .at_max    (w_at_max[p]),
        .underflow (w_underflow[p])
      );
    end else begin : g_untrk
      // Pipes beyond NPIPES are never counted or retried.
      assign w_cnt[p]       = 3'd0;
      assign w_at_max[p]    = 1'b0;
      assign w_underflow[p] = 1'b0;
    end
  end

  // Sticky flag: a response came back for a pipe with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credit_err <= 1'b0;
    end else if (|w_underflow) begin
      r_credit_err <= 1'b1;
    end
  end
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_l2todr_req_credit.sv
// Directed bench for l2todr_req_credit (MAX_OUT=4, four pipes).
module tb_l2todr_req_credit;
  import l2todr_req_credit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               in_req_valid = 1'b0;
  logic               in_req_retry;
  I_l2todr_req_type   in_req = '0;
  logic               l2todr_req_valid;
  logic               l2todr_req_retry = 1'b0;
  I_l2todr_req_type   l2todr_req;
  logic               drtol2_snack_valid = 1'b0;
  logic               drtol2_snack_retry;
  I_drtol2_snack_type drtol2_snack = '0;
  logic               out_snack_valid;
  logic               out_snack_retry = 1'b0;
  I_drtol2_snack_type out_snack;
  logic               credit_err;

  l2todr_req_credit #(.MAX_OUT(4), .NPIPES(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_req_valid       (in_req_valid),
    .in_req_retry       (in_req_retry),
    .in_req             (in_req),
    .l2todr_req_valid   (l2todr_req_valid),
    .l2todr_req_retry   (l2todr_req_retry),
    .l2todr_req         (l2todr_req),
    .drtol2_snack_valid (drtol2_snack_valid),
    .drtol2_snack_retry (drtol2_snack_retry),
    .drtol2_snack       (drtol2_snack),
    .out_snack_valid    (out_snack_valid),
    .out_snack_retry    (out_snack_retry),
    .out_snack          (out_snack),
    .credit_err         (credit_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic v, input logic [4:0] nid, input logic [5:0] l2id);
    in_req_valid = v;
    in_req       = '0;
    in_req.nid   = nid;
    in_req.l2id  = l2id;
    in_req.cmd   = 3'd1;
    in_req.paddr = {33'd0, l2id};
  endtask

  task automatic set_snk(input logic v, input logic [4:0] nid, input logic [5:0] l2id);
    drtol2_snack_valid = v;
    drtol2_snack       = '0;
    drtol2_snack.nid   = nid;
    drtol2_snack.l2id  = l2id;
    drtol2_snack.snack = 3'd2;
    drtol2_snack.line  = {26'd0, l2id};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_req(1'b0, 5'd0, 6'd0);
    set_snk(1'b0, 5'd0, 6'd0);
    l2todr_req_retry = 1'b0;
    out_snack_retry  = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rv;
    logic [4:0] rnid;
    logic [5:0] rl2id;
    logic       sv;
    logic [4:0] snid;
    logic [5:0] sl2id;
    logic       e_irr;
    logic       e_lv;
    logic [5:0] e_ll2id;
    logic       e_ov;
    logic [5:0] e_sl2id;
    logic [2:0] e_c0;
    logic [2:0] e_c1;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input int rv, input int rnid, input int rl2id,
                              input int sv, input int snid, input int sl2id,
                              input int e_irr, input int e_lv, input int e_ll2id,
                              input int e_ov, input int e_sl2id,
                              input int e_c0, input int e_c1);
    vec_t v;
    v.rv = 1'(rv);      v.rnid = 5'(rnid);     v.rl2id = 6'(rl2id);
    v.sv = 1'(sv);      v.snid = 5'(snid);     v.sl2id = 6'(sl2id);
    v.e_irr = 1'(e_irr); v.e_lv = 1'(e_lv);    v.e_ll2id = 6'(e_ll2id);
    v.e_ov = 1'(e_ov);  v.e_sl2id = 6'(e_sl2id);
    v.e_c0 = 3'(e_c0);  v.e_c1 = 3'(e_c1);
    return v;
  endfunction

  initial begin
    // pipe1 (nid 8) saturates, pipe0 (nid 1) still flows, then saturates
    tbl[0]  = mk(1, 8, 10, 0, 0, 0, 0, 1, 10, 0, 0, 0, 1);
    tbl[1]  = mk(1, 8, 11, 0, 0, 0, 0, 1, 11, 0, 0, 0, 2);
    tbl[2]  = mk(1, 8, 12, 0, 0, 0, 0, 1, 12, 0, 0, 0, 3);
    tbl[3]  = mk(1, 8, 13, 0, 0, 0, 0, 1, 13, 0, 0, 0, 4);
    tbl[4]  = mk(1, 1,  1, 0, 0, 0, 0, 1,  1, 0, 0, 1, 4);
    tbl[5]  = mk(1, 1,  2, 0, 0, 0, 0, 1,  2, 0, 0, 2, 4);
    tbl[6]  = mk(1, 1,  3, 0, 0, 0, 0, 1,  3, 0, 0, 3, 4);
    tbl[7]  = mk(1, 1,  4, 0, 0, 0, 0, 1,  4, 0, 0, 4, 4);
    tbl[8]  = mk(1, 1,  5, 0, 0, 0, 1, 0,  0, 0, 0, 4, 4);
    tbl[9]  = mk(1, 1,  5, 1, 1, 3, 1, 0,  0, 1, 3, 4, 4);
    tbl[10] = mk(1, 1,  5, 0, 0, 0, 1, 0,  0, 0, 0, 3, 4);
    tbl[11] = mk(1, 1,  5, 0, 0, 0, 0, 1,  5, 0, 0, 4, 4);
    tbl[12] = mk(1, 8, 14, 0, 0, 0, 1, 0,  0, 0, 0, 4, 4);
    tbl[13] = mk(1, 8, 14, 1, 8, 7, 1, 0,  0, 1, 7, 4, 4);
    tbl[14] = mk(1, 8, 14, 0, 0, 0, 1, 0,  0, 0, 0, 4, 3);
    tbl[15] = mk(1, 8, 14, 0, 0, 0, 0, 1, 14, 0, 0, 4, 4);
    tbl[16] = mk(0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 4, 4);

    // reset values
    tick();
    tick();
    chk("rst_req_valid", 32'(l2todr_req_valid), 32'd0);
    chk("rst_snk_valid", 32'(out_snack_valid), 32'd0);
    chk("rst_in_retry", 32'(in_req_retry), 32'd0);
    chk("rst_snk_retry", 32'(drtol2_snack_retry), 32'd0);
    chk("rst_err", 32'(credit_err), 32'd0);
    for (int p = 0; p < 4; p++) chk($sformatf("rst_cnt%0d", p), 32'(dut.w_cnt[p]), 32'd0);
    reset = 1'b0;

    // ---- table: saturation, release, pipe independence ----
    for (int i = 0; i < 17; i++) begin
      set_req(tbl[i].rv, tbl[i].rnid, tbl[i].rl2id);
      set_snk(tbl[i].sv, tbl[i].snid, tbl[i].sl2id);
      #1;
      chk($sformatf("v%0d_in_retry", i), 32'(in_req_retry), 32'(tbl[i].e_irr));
      chk($sformatf("v%0d_snk_retry", i), 32'(drtol2_snack_retry), 32'd0);
      tick();
      chk($sformatf("v%0d_req_valid", i), 32'(l2todr_req_valid), 32'(tbl[i].e_lv));
      if (tbl[i].e_lv)
        chk($sformatf("v%0d_req_l2id", i), 32'(l2todr_req.l2id), 32'(tbl[i].e_ll2id));
      chk($sformatf("v%0d_snk_valid", i), 32'(out_snack_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov)
        chk($sformatf("v%0d_snk_l2id", i), 32'(out_snack.l2id), 32'(tbl[i].e_sl2id));
      chk($sformatf("v%0d_cnt0", i), 32'(dut.w_cnt[0]), 32'(tbl[i].e_c0));
      chk($sformatf("v%0d_cnt1", i), 32'(dut.w_cnt[1]), 32'(tbl[i].e_c1));
      chk($sformatf("v%0d_err", i), 32'(credit_err), 32'd0);
    end

    // ---- simultaneous inc/dec on pipe2 ----
    do_reset();
    set_req(1'b1, 5'd16, 6'd1); tick();
    set_req(1'b1, 5'd16, 6'd2); tick();
    chk("sim_setup_cnt2", 32'(dut.w_cnt[2]), 32'd2);
    set_req(1'b0, 5'd0, 6'd0);
    set_snk(1'b1, 5'd16, 6'd9); tick();
    chk("sim_snk_valid", 32'(out_snack_valid), 32'd1);
    set_snk(1'b0, 5'd0, 6'd0);
    set_req(1'b1, 5'd16, 6'd3);
    #1 chk("sim_in_retry", 32'(in_req_retry), 32'd0);
    tick();
    chk("sim_cnt2", 32'(dut.w_cnt[2]), 32'd2);
    chk("sim_req_l2id", 32'(l2todr_req.l2id), 32'd3);
    chk("sim_snk_gone", 32'(out_snack_valid), 32'd0);
    set_req(1'b0, 5'd0, 6'd0); tick();
    chk("sim_cnt2_hold", 32'(dut.w_cnt[2]), 32'd2);

    // ---- snoop vs underflow on pipe3 ----
    set_snk(1'b1, 5'd24, 6'd0); tick();
    chk("snoop_valid", 32'(out_snack_valid), 32'd1);
    chk("snoop_l2id", 32'(out_snack.l2id), 32'd0);
    set_snk(1'b0, 5'd0, 6'd0); tick();
    chk("snoop_cnt3", 32'(dut.w_cnt[3]), 32'd0);
    chk("snoop_err", 32'(credit_err), 32'd0);
    set_snk(1'b1, 5'd24, 6'd5); tick();
    chk("uf_err_early", 32'(credit_err), 32'd0);
    set_snk(1'b0, 5'd0, 6'd0); tick();
    chk("uf_err", 32'(credit_err), 32'd1);
    chk("uf_cnt3", 32'(dut.w_cnt[3]), 32'd0);
    tick(); tick();
    chk("uf_err_sticky", 32'(credit_err), 32'd1);

    // ---- back-pressure: directory retry ----
    do_reset();
    l2todr_req_retry = 1'b1;
    set_req(1'b1, 5'd1, 6'd1); tick();
    chk("bp_load_valid", 32'(l2todr_req_valid), 32'd1);
    chk("bp_load_cnt0", 32'(dut.w_cnt[0]), 32'd1);
    set_req(1'b1, 5'd1, 6'd2);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp%0d_in_retry", k), 32'(in_req_retry), 32'd1);
      tick();
      chk($sformatf("bp%0d_valid", k), 32'(l2todr_req_valid), 32'd1);
      chk($sformatf("bp%0d_l2id", k), 32'(l2todr_req.l2id), 32'd1);
      chk($sformatf("bp%0d_cnt0", k), 32'(dut.w_cnt[0]), 32'd1);
    end
    l2todr_req_retry = 1'b0;
    #1 chk("bp_rel_in_retry", 32'(in_req_retry), 32'd0);
    tick();
    chk("bp_rel_l2id", 32'(l2todr_req.l2id), 32'd2);
    chk("bp_rel_cnt0", 32'(dut.w_cnt[0]), 32'd2);
    set_req(1'b0, 5'd0, 6'd0); tick();
    chk("bp_drain_valid", 32'(l2todr_req_valid), 32'd0);

    // ---- back-pressure: arbiter retry on snack ----
    out_snack_retry = 1'b1;
    set_snk(1'b1, 5'd1, 6'd7); tick();
    set_snk(1'b0, 5'd0, 6'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("sbp%0d_valid", k), 32'(out_snack_valid), 32'd1);
      chk($sformatf("sbp%0d_l2id", k), 32'(out_snack.l2id), 32'd7);
      chk($sformatf("sbp%0d_cnt0", k), 32'(dut.w_cnt[0]), 32'd2);
    end
    set_snk(1'b1, 5'd1, 6'd0);
    #1 chk("sbp_dir_retry", 32'(drtol2_snack_retry), 32'd1);
    out_snack_retry = 1'b0;
    tick();
    chk("sbp_rel_cnt0", 32'(dut.w_cnt[0]), 32'd1);
    chk("sbp_next_l2id", 32'(out_snack.l2id), 32'd0);
    set_snk(1'b0, 5'd0, 6'd0); tick();
    chk("sbp_snoop_cnt0", 32'(dut.w_cnt[0]), 32'd1);
    chk("sbp_drain_valid", 32'(out_snack_valid), 32'd0);

    // ---- reset mid-stream ----
    set_snk(1'b1, 5'd24, 6'd5); tick();
    set_snk(1'b0, 5'd0, 6'd0); tick();
    chk("mid_err_set", 32'(credit_err), 32'd1);
    set_req(1'b1, 5'd1, 6'd3); tick();
    set_req(1'b1, 5'd1, 6'd4); tick();
    set_req(1'b0, 5'd0, 6'd0);
    l2todr_req_retry = 1'b1;
    out_snack_retry  = 1'b1;
    set_snk(1'b1, 5'd1, 6'd0); tick();
    set_snk(1'b0, 5'd0, 6'd0);
    chk("mid_cnt0", 32'(dut.w_cnt[0]), 32'd3);
    chk("mid_req_full", 32'(l2todr_req_valid), 32'd1);
    chk("mid_snk_full", 32'(out_snack_valid), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mrst_req_valid", 32'(l2todr_req_valid), 32'd0);
    chk("mrst_snk_valid", 32'(out_snack_valid), 32'd0);
    chk("mrst_cnt0", 32'(dut.w_cnt[0]), 32'd0);
    chk("mrst_err", 32'(credit_err), 32'd0);
    chk("mrst_in_retry", 32'(in_req_retry), 32'd0);
    chk("mrst_snk_retry", 32'(drtol2_snack_retry), 32'd0);
    l2todr_req_retry = 1'b0;
    out_snack_retry  = 1'b0;
    tick();

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
